// File: rtl/nw_fill_sequencer.sv
// nw_fill_sequencer
//   Drives the (N+1)x(N+1) Needleman-Wunsch score/traceback RAM. It writes
//   row 0 and column 0 first, then walks the remaining cells in raster order.
//   For each cell it requests the three neighbour scores, scores the cell and
//   writes the score and traceback symbol. In local (Smith-Waterman) mode,
//   scores are clamped at zero and the best cell seen so far is tracked.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   start               begin init + fill (only looked at while idle)
//   busy / done         busy from leaving IDLE until done; done is a 1-cycle pulse
//   i, j                current fill cell (row, column)
//   rd_req / rd_valid   neighbour-score read handshake for cell (i,j)
//   match               seqA[i-1] == seqB[j-1]
//   diag, up, left      signed neighbour scores (valid with rd_valid)
//   wr_en, wr_addr      RAM write strobe and linear address row*(N+1)+col
//   wr_score, wr_symbol signed score and traceback bits {diag,up,left}
//   best_score/i/j      local mode: best cell so far (all zero in global mode)

module nw_fill_sequencer #(
  parameter int N              = 128,
  parameter int SCORE_W        = 9,
  parameter int ADDR_W         = $clog2((N+1)*(N+1)),
  parameter int IDX_W          = $clog2(N+1),
  parameter int GAP_SCORE      = -2,
  parameter int MATCH_SCORE    = 1,
  parameter int MISMATCH_SCORE = -1,
  parameter int LOCAL_MODE     = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic [IDX_W-1:0]   i,
  output logic [IDX_W-1:0]   j,
  output logic               rd_req,
  input  logic               rd_valid,
  input  logic               match,
  input  logic [SCORE_W-1:0] diag,
  input  logic [SCORE_W-1:0] up,
  input  logic [SCORE_W-1:0] left,
  output logic               wr_en,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [SCORE_W-1:0] wr_score,
  output logic [2:0]         wr_symbol,
  output logic [SCORE_W-1:0] best_score,
  output logic [IDX_W-1:0]   best_i,
  output logic [IDX_W-1:0]   best_j
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_INIT  = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_CALC  = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  // Init counter runs 0..2N, so it needs one bit more than a row index.
  localparam int CNT_W   = IDX_W + 1;
  localparam int SAT_MAX = (1 << (SCORE_W-1)) - 1;
  localparam int SAT_MIN = -(1 << (SCORE_W-1));
  localparam logic [ADDR_W-1:0] ROW_STRIDE = ADDR_W'(N+1);

  // Arithmetic is done in 32-bit int so no intermediate sum can wrap before
  // it is clamped into the signed SCORE_W range.
  function automatic logic [SCORE_W-1:0] sat(input int v);
    if (v > SAT_MAX)      return SCORE_W'(SAT_MAX);
    else if (v < SAT_MIN) return SCORE_W'(SAT_MIN);
    else                  return SCORE_W'(v);
  endfunction

  logic [2:0]         r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [IDX_W-1:0]   r_i, r_j;
  logic [SCORE_W-1:0] r_diag, r_up, r_left;
  logic               r_match;
  logic [SCORE_W-1:0] r_m;
  logic [2:0]         r_sym;
  logic [SCORE_W-1:0] r_best_score;
  logic [IDX_W-1:0]   r_best_i, r_best_j;

  // Init sequence: count 0..N is row 0 (0,k); count N+1..2N is column 0 (k-N,0).
  logic               w_init_row0;
  logic [IDX_W-1:0]   w_init_idx;
  logic [ADDR_W-1:0]  w_init_addr;
  logic [SCORE_W-1:0] w_init_score;

  assign w_init_row0  = (r_cnt <= CNT_W'(N));
  assign w_init_idx   = w_init_row0 ? r_cnt[IDX_W-1:0] : IDX_W'(r_cnt - CNT_W'(N));
  assign w_init_addr  = w_init_row0 ? ADDR_W'(w_init_idx) : ADDR_W'(w_init_idx) * ROW_STRIDE;
  assign w_init_score = (LOCAL_MODE != 0) ? '0 : sat(int'(w_init_idx) * GAP_SCORE);

  // Cell scoring from the captured operands.
  logic signed [SCORE_W-1:0] w_ds, w_us, w_ls, w_max;
  logic [2:0]                w_sym;

  always_comb begin
    w_ds  = sat(int'($signed(r_diag)) + (r_match ? MATCH_SCORE : MISMATCH_SCORE));
    w_us  = sat(int'($signed(r_up)) + GAP_SCORE);
    w_ls  = sat(int'($signed(r_left)) + GAP_SCORE);
    w_max = w_ds;
    if (w_us > w_max) w_max = w_us;
    if (w_ls > w_max) w_max = w_ls;
    // Every candidate equal to the maximum is flagged, so ties set several bits.
    w_sym = {w_ds == w_max, w_us == w_max, w_ls == w_max};
    if (LOCAL_MODE != 0 && w_max < 0) begin
      w_max = '0;
      w_sym = 3'b000;
    end
  end

  logic [ADDR_W-1:0] w_cell_addr;
  assign w_cell_addr = ADDR_W'(r_i) * ROW_STRIDE + ADDR_W'(r_j);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_i          <= '0;
      r_j          <= '0;
      r_diag       <= '0;
      r_up         <= '0;
      r_left       <= '0;
      r_match      <= 1'b0;
      r_m          <= '0;
      r_sym        <= '0;
      r_best_score <= '0;
      r_best_i     <= '0;
      r_best_j     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state      <= S_INIT;
            r_cnt        <= '0;
            r_i          <= '0;
            r_j          <= '0;
            r_best_score <= '0;
            r_best_i     <= '0;
            r_best_j     <= '0;
          end
        end
        S_INIT: begin
          if (r_cnt == CNT_W'(2*N)) begin
            r_state <= S_WAIT;
            r_i     <= IDX_W'(1);
            r_j     <= IDX_W'(1);
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_WAIT: begin
          if (rd_valid) begin
            r_diag  <= diag;
            r_up    <= up;
            r_left  <= left;
            r_match <= match;
            r_state <= S_CALC;
          end
        end
        S_CALC: begin
          r_m     <= w_max;
          r_sym   <= w_sym;
          r_state <= S_WRITE;
        end
        S_WRITE: begin
          // Strictly greater: the earliest cell in raster order keeps a tie.
          if (LOCAL_MODE != 0 && $signed(r_m) > $signed(r_best_score)) begin
            r_best_score <= r_m;
            r_best_i     <= r_i;
            r_best_j     <= r_j;
          end
          // The last cell leaves (i,j) parked at (N,N) rather than stepping past it.
          if (r_i == IDX_W'(N) && r_j == IDX_W'(N)) begin
            r_state <= S_DONE;
          end else begin
            r_state <= S_WAIT;
            if (r_j != IDX_W'(N)) begin
              r_j <= r_j + IDX_W'(1);
            end else begin
              r_j <= IDX_W'(1);
              r_i <= r_i + IDX_W'(1);
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy   = (r_state == S_INIT) || (r_state == S_WAIT) ||
                  (r_state == S_CALC) || (r_state == S_WRITE);
  assign done   = (r_state == S_DONE);
  assign rd_req = (r_state == S_WAIT);
  assign wr_en  = (r_state == S_INIT) || (r_state == S_WRITE);

  always_comb begin
    wr_addr   = '0;
    wr_score  = '0;
    wr_symbol = 3'b000;
    if (r_state == S_INIT) begin
      wr_addr  = w_init_addr;
      wr_score = w_init_score;
    end else if (r_state == S_WRITE) begin
      wr_addr   = w_cell_addr;
      wr_score  = r_m;
      wr_symbol = r_sym;
    end
  end

  assign i          = r_i;
  assign j          = r_j;
  assign best_score = r_best_score;
  assign best_i     = r_best_i;
  assign best_j     = r_best_j;

endmodule

// File: tb/tb_nw_fill_sequencer.sv
// Testbench for nw_fill_sequencer: a global N=4 instance, a local N=4 instance
// and a global N=200 instance used for the clamped init sequence. Expected
// writes are queued when stimulus is issued and popped by monitor processes.

module tb_nw_fill_sequencer;

  localparam int N   = 4;
  localparam int SW  = 9;
  localparam int AW  = 5;
  localparam int IW  = 3;
  localparam int BN  = 200;
  localparam int BAW = 16;
  localparam int BIW = 8;
  localparam int GAP = -2;

  typedef struct packed {
    logic [15:0]   addr;
    logic [SW-1:0] score;
    logic [2:0]    sym;
  } wr_t;

  int total = 0;
  int bad   = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, rst_b;
  logic start0, start1, start_b;
  logic rd_valid, match;
  logic [SW-1:0] diag, up, left;

  logic busy0, done0, rd_req0, wr_en0, busy1, done1, rd_req1, wr_en1;
  logic [IW-1:0] i0, j0, bi0, bj0, i1, j1, bi1, bj1;
  logic [AW-1:0] wa0, wa1;
  logic [SW-1:0] ws0, bs0, ws1, bs1;
  logic [2:0]    wy0, wy1;

  logic           b_busy, b_done, b_rd_req, b_wr_en;
  logic [BIW-1:0] b_i, b_j, b_bi, b_bj;
  logic [BAW-1:0] b_wa;
  logic [SW-1:0]  b_ws, b_bs;
  logic [2:0]     b_wy;

  nw_fill_sequencer #(.N(N), .SCORE_W(SW), .LOCAL_MODE(0)) u_glob (
    .clk(clk), .rst(rst), .start(start0), .busy(busy0), .done(done0),
    .i(i0), .j(j0), .rd_req(rd_req0), .rd_valid(rd_valid), .match(match),
    .diag(diag), .up(up), .left(left), .wr_en(wr_en0), .wr_addr(wa0),
    .wr_score(ws0), .wr_symbol(wy0), .best_score(bs0), .best_i(bi0), .best_j(bj0));

  nw_fill_sequencer #(.N(N), .SCORE_W(SW), .LOCAL_MODE(1)) u_loc (
    .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1),
    .i(i1), .j(j1), .rd_req(rd_req1), .rd_valid(rd_valid), .match(match),
    .diag(diag), .up(up), .left(left), .wr_en(wr_en1), .wr_addr(wa1),
    .wr_score(ws1), .wr_symbol(wy1), .best_score(bs1), .best_i(bi1), .best_j(bj1));

  nw_fill_sequencer #(.N(BN), .SCORE_W(SW), .LOCAL_MODE(0)) u_big (
    .clk(clk), .rst(rst_b), .start(start_b), .busy(b_busy), .done(b_done),
    .i(b_i), .j(b_j), .rd_req(b_rd_req), .rd_valid(1'b0), .match(1'b0),
    .diag('0), .up('0), .left('0), .wr_en(b_wr_en), .wr_addr(b_wa),
    .wr_score(b_ws), .wr_symbol(b_wy), .best_score(b_bs), .best_i(b_bi), .best_j(b_bj));

  // View of whichever small instance is currently being exercised.
  logic sel;
  logic s_busy, s_done, s_rd_req, s_wr_en, s_other_wr_en;
  logic [IW-1:0] s_i, s_j, s_bi, s_bj;
  logic [15:0] s_wr_addr;
  logic signed [SW-1:0] s_wr_score, s_best_score;
  logic [2:0] s_wr_symbol;

  assign s_busy        = sel ? busy1 : busy0;
  assign s_done        = sel ? done1 : done0;
  assign s_rd_req      = sel ? rd_req1 : rd_req0;
  assign s_wr_en       = sel ? wr_en1 : wr_en0;
  assign s_other_wr_en = sel ? wr_en0 : wr_en1;
  assign s_i           = sel ? i1 : i0;
  assign s_j           = sel ? j1 : j0;
  assign s_bi          = sel ? bi1 : bi0;
  assign s_bj          = sel ? bj1 : bj0;
  assign s_wr_addr     = 16'(sel ? wa1 : wa0);
  assign s_wr_score    = $signed(sel ? ws1 : ws0);
  assign s_best_score  = $signed(sel ? bs1 : bs0);
  assign s_wr_symbol   = sel ? wy1 : wy0;

  wr_t exp_q[$];
  wr_t big_q[$];

  // Reference model state: full score matrix, raster position, best cell.
  int H [0:N][0:N];
  int seq_a [N];
  int seq_b [N];
  int mi, mj, mbest, mbi, mbj;

  function automatic int satm(input int v);
    if (v > 255)  return 255;
    if (v < -256) return -256;
    return v;
  endfunction

  function automatic void model_cell(input int dg, input int u, input int l, input bit mt,
                                     input bit lm, output int m, output logic [2:0] sym);
    int cand [3];
    cand[0] = satm(dg + (mt ? 1 : -1));
    cand[1] = satm(u + GAP);
    cand[2] = satm(l + GAP);
    m = cand[0];
    foreach (cand[k]) if (cand[k] > m) m = cand[k];
    sym = {cand[0] == m, cand[1] == m, cand[2] == m};
    if (lm && m < 0) begin
      m = 0;
      sym = 3'b000;
    end
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  // Monitor for the two N=4 instances.
  always @(negedge clk) begin
    wr_t e;
    if (s_other_wr_en === 1'b1) begin
      total++; bad++;
      $display("FAIL stray_write: idle instance asserted wr_en");
    end
    if (s_wr_en === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write: addr=%0d score=%0d sym=%b", s_wr_addr, s_wr_score, s_wr_symbol);
      end else begin
        e = exp_q.pop_front();
        if (s_wr_addr != e.addr || s_wr_score != $signed(e.score) ||
            s_wr_symbol != e.sym || s_rd_req !== 1'b0) begin
          bad++;
          $display("FAIL write: actual addr=%0d score=%0d sym=%b rd_req=%b required addr=%0d score=%0d sym=%b rd_req=0",
                   s_wr_addr, s_wr_score, s_wr_symbol, s_rd_req, e.addr, $signed(e.score), e.sym);
        end
      end
    end
  end

  // Monitor for the N=200 instance.
  always @(negedge clk) begin
    wr_t e;
    if (b_wr_en === 1'b1) begin
      total++;
      if (big_q.size() == 0) begin
        bad++;
        $display("FAIL big_unexpected_write: addr=%0d", b_wa);
      end else begin
        e = big_q.pop_front();
        if (b_wa != e.addr || b_ws != e.score || b_wy != e.sym) begin
          bad++;
          $display("FAIL big_write: actual addr=%0d score=%0d sym=%b required addr=%0d score=%0d sym=%b",
                   b_wa, $signed(b_ws), b_wy, e.addr, $signed(e.score), e.sym);
        end
      end
    end
  end

  task automatic wait_rd_req(output bit ok);
    int c;
    ok = 0;
    c = 0;
    while (!ok && c < 40) begin
      @(negedge clk);
      if (s_rd_req === 1'b1) ok = 1;
      c++;
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL rd_req_timeout: actual=0 required=1 within 40 cycles");
    end
  endtask

  task automatic do_start(input bit lm);
    wr_t e;
    int idx, sc;
    for (int k = 0; k <= 2*N; k++) begin
      idx     = (k <= N) ? k : k - N;
      sc      = lm ? 0 : satm(GAP * idx);
      e.addr  = 16'((k <= N) ? idx : idx * (N+1));
      e.score = SW'(sc);
      e.sym   = 3'b000;
      exp_q.push_back(e);
      if (k <= N) H[0][idx] = sc; else H[idx][0] = sc;
    end
    sel = lm;
    if (lm) start1 = 1'b1; else start0 = 1'b1;
    @(negedge clk);
    chk("busy_after_start", s_busy, 1);
    chk("best_cleared_by_start", s_best_score, 0);
    @(negedge clk);   // start still high while busy: must be ignored
    start0 = 1'b0;
    start1 = 1'b0;
    mi = 1; mj = 1; mbest = 0; mbi = 0; mbj = 0;
  endtask

  // Called at a negedge where rd_req is high for the model's current cell.
  task automatic serve_cell(input int dg, input int u, input int l, input bit mt,
                            input int dly, input bit lm);
    wr_t e;
    int m;
    logic [2:0] sym;
    chk("cell_i", s_i, mi);
    chk("cell_j", s_j, mj);
    for (int k = 0; k < dly; k++) begin
      @(negedge clk);
      chk("rd_req_held", s_rd_req, 1);
    end
    diag = SW'(dg); up = SW'(u); left = SW'(l); match = mt; rd_valid = 1'b1;
    model_cell(dg, u, l, mt, lm, m, sym);
    e.addr = 16'(mi * (N+1) + mj); e.score = SW'(m); e.sym = sym;
    exp_q.push_back(e);
    @(negedge clk);
    chk("calc_quiet", {s_wr_en, s_rd_req}, 0);
    // Noise while not in WAIT; the captured operands must be the ones used.
    diag = SW'($urandom); up = SW'($urandom); left = SW'($urandom);
    match = 1'($urandom); rd_valid = 1'b1;
    @(negedge clk);
    chk("write_latency", s_wr_en, 1);
    rd_valid = 1'b0;
    H[mi][mj] = m;
    if (lm && m > mbest) begin mbest = m; mbi = mi; mbj = mj; end
    if (mj < N) mj++; else begin mj = 1; mi++; end
  endtask

  task automatic run_fill(input bit lm, input bit stop_at_23, output bit stopped);
    bit ok, mt;
    int dg, u, l, dly;
    stopped = 0;
    for (int c = 0; c < N*N; c++) begin
      wait_rd_req(ok);
      if (!ok) return;
      if (stop_at_23 && mi == 2 && mj == 3) begin stopped = 1; return; end
      dly = $urandom_range(3);
      mt  = 1'($urandom_range(1));
      if (!lm) begin
        if (c == 0)      begin dg = 0;   u = -2;   l = -2;  mt = 1; dly = 0; end
        else if (c == 1) begin dg = 0;   u = 1;    l = 1;   mt = 0; dly = 5; end
        else if (c == 2) begin dg = 255; u = -256; l = 100; mt = 1; end
        else if ($urandom_range(1) == 1) begin
          dg = H[mi-1][mj-1]; u = H[mi-1][mj]; l = H[mi][mj-1];
          mt = (seq_a[mi-1] == seq_b[mj-1]);
        end else begin
          dg = int'($urandom_range(511)) - 256;
          u  = int'($urandom_range(511)) - 256;
          l  = int'($urandom_range(511)) - 256;
        end
      end else begin
        if (c == 0) begin dg = -3; u = -2; l = -5; mt = 0; end
        else if (c == 5 || c == 10) begin dg = 2; u = 0; l = 0; mt = 1; end
        else begin
          dg = int'($urandom_range(6)) - 5;
          u  = int'($urandom_range(6)) - 5;
          l  = int'($urandom_range(6)) - 5;
        end
      end
      serve_cell(dg, u, l, mt, dly, lm);
    end
  endtask

  task automatic check_done();
    @(negedge clk);
    chk("done_pulse", s_done, 1);
    chk("busy_low_with_done", s_busy, 0);
    @(negedge clk);
    chk("done_single_cycle", s_done, 0);
    chk("pending_writes", exp_q.size(), 0);
    chk("best_score", s_best_score, mbest);
    chk("best_i", s_bi, mbi);
    chk("best_j", s_bj, mbj);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit stopped, ok;
    wr_t e;
    int cnt;
    rst = 1'b1; rst_b = 1'b1; sel = 1'b0;
    start0 = 1'b0; start1 = 1'b0; start_b = 1'b0;
    rd_valid = 1'b0; match = 1'b0; diag = '0; up = '0; left = '0;
    foreach (seq_a[k]) seq_a[k] = int'($urandom_range(3));
    foreach (seq_b[k]) seq_b[k] = int'($urandom_range(3));
    repeat (3) @(negedge clk);
    chk("reset_busy", s_busy, 0);
    chk("reset_done", s_done, 0);
    chk("reset_rd_req", s_rd_req, 0);
    chk("reset_wr_en", s_wr_en, 0);
    chk("reset_i", s_i, 0);
    chk("reset_best", s_best_score, 0);
    chk("reset_local_busy", busy1, 0);
    rst = 1'b0; rst_b = 1'b0;

    // Large instance: only its clamped init sequence is examined.
    for (int k = 0; k <= 2*BN; k++) begin
      cnt     = (k <= BN) ? k : k - BN;
      e.addr  = 16'((k <= BN) ? cnt : cnt * (BN+1));
      e.score = SW'(satm(GAP * cnt));
      e.sym   = 3'b000;
      big_q.push_back(e);
    end
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;

    // Global full run.
    do_start(1'b0);
    run_fill(1'b0, 1'b0, stopped);
    check_done();

    // Local full run, then a second local run aborted at cell (2,3).
    do_start(1'b1);
    run_fill(1'b1, 1'b0, stopped);
    check_done();
    do_start(1'b1);
    run_fill(1'b1, 1'b1, stopped);
    chk("reached_cell_2_3", stopped, 1);
    chk("best_before_abort", s_best_score, 3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", s_busy, 0);
    chk("abort_done", s_done, 0);
    chk("abort_rd_req", s_rd_req, 0);
    chk("abort_wr_en", s_wr_en, 0);
    chk("abort_i", s_i, 0);
    chk("abort_j", s_j, 0);
    chk("abort_wr_addr", s_wr_addr, 0);
    chk("abort_wr_score", s_wr_score, 0);
    chk("abort_wr_symbol", s_wr_symbol, 0);
    chk("abort_best_score", s_best_score, 0);
    chk("abort_best_i", s_bi, 0);
    chk("abort_best_j", s_bj, 0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("no_done_after_abort", s_done, 0);
      chk("idle_after_abort", s_busy, 0);
    end
    chk("no_pending_after_abort", exp_q.size(), 0);

    // Fresh start re-runs init from address 0.
    do_start(1'b1);
    wait_rd_req(ok);
    chk("restart_i", s_i, 1);
    chk("restart_j", s_j, 1);
    chk("restart_init_consumed", exp_q.size(), 0);

    cnt = 0;
    while (big_q.size() != 0 && cnt < 600) begin
      @(negedge clk);
      cnt++;
    end
    chk("big_init_writes_left", big_q.size(), 0);
    chk("big_rd_req_after_init", b_rd_req, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
